// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V control unit: a Moore FSM that sequences each instruction over
// 3-5 cycles on a shared memory, with wait states, jal/lui, an illegal-opcode trap and a retire counter.
module multicycle_control_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit J_EN        = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0]       OP,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOP,
  output logic [2:0]       ImmSrc,
  output logic             Illegal,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b000_0011;
  localparam logic [6:0] OP_SW  = 7'b010_0011;
  localparam logic [6:0] OP_R   = 7'b011_0011;
  localparam logic [6:0] OP_I   = 7'b001_0011;
  localparam logic [6:0] OP_BEQ = 7'b110_0011;
  localparam logic [6:0] OP_JAL = 7'b110_1111;
  localparam logic [6:0] OP_LUI = 7'b011_0111;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             w_ready;
  logic             w_pcUpdate;
  logic             w_branch;
  logic             w_irWrite;
  logic             w_memWrite;
  logic             w_regWrite;

  assign w_ready = MemReady | ~MEM_WAIT_EN;

  // Retiring states bump the counter on the same edge that returns to FETCH.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_FETCH;
      r_count <= '0;
    end else begin
      case (r_state)
        S_FETCH:    if (w_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (OP)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_R:         r_state <= S_EXECR;
            OP_I:         r_state <= S_EXECI;
            OP_BEQ:       r_state <= S_BEQ;
            OP_JAL:       r_state <= J_EN ? S_JAL : S_TRAP;
            OP_LUI:       r_state <= J_EN ? S_LUI : S_TRAP;
            default:      r_state <= S_TRAP;
          endcase
        end
        S_MEMADR:   r_state <= (OP == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (w_ready) r_state <= S_MEMWB;
        S_MEMWRITE: begin
          if (w_ready) begin
            r_state <= S_FETCH;
            r_count <= r_count + CNT_W'(1);
          end
        end
        S_MEMWB, S_ALUWB, S_BEQ: begin
          r_state <= S_FETCH;
          r_count <= r_count + CNT_W'(1);
        end
        S_EXECR, S_EXECI, S_JAL, S_LUI: r_state <= S_ALUWB;
        S_TRAP:     r_state <= S_TRAP;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOP      = 2'b00;
    Illegal    = 1'b0;
    w_pcUpdate = 1'b0;
    w_branch   = 1'b0;
    w_irWrite  = 1'b0;
    w_memWrite = 1'b0;
    w_regWrite = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        w_irWrite  = w_ready;
        w_pcUpdate = w_ready;
      end
      S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB:    begin ResultSrc = 2'b01; w_regWrite = 1'b1; end
      S_MEMWRITE: begin AdrSrc = 1'b1; w_memWrite = 1'b1; end
      S_EXECR:    begin ALUSrcA = 2'b10; ALUOP = 2'b10; end
      S_EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOP = 2'b10; end
      S_ALUWB:    w_regWrite = 1'b1;
      S_BEQ:      begin ALUSrcA = 2'b10; ALUOP = 2'b01; w_branch = 1'b1; end
      S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; w_pcUpdate = 1'b1; end
      S_LUI:      begin ALUSrcA = 2'b11; ALUSrcB = 2'b01; end
      S_TRAP:     Illegal = 1'b1;
      default:    Illegal = 1'b0;
    endcase
  end

  always_comb begin
    case (OP)
      OP_SW:   ImmSrc = 3'b001;
      OP_BEQ:  ImmSrc = 3'b010;
      OP_JAL:  ImmSrc = 3'b011;
      OP_LUI:  ImmSrc = 3'b100;
      default: ImmSrc = 3'b000;
    endcase
  end

  // Gating with RST keeps FETCH's MemReady-driven strobes quiet while reset is held.
  assign PCWrite    = RST & (w_pcUpdate | (w_branch & Zero));
  assign IRWrite    = RST & w_irWrite;
  assign MemWrite   = RST & w_memWrite;
  assign RegWrite   = RST & w_regWrite;
  assign State      = r_state;
  assign InstrCount = r_count;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Testbench for multicycle_control_fsm: default instance plus a second instance with
// MEM_WAIT_EN=0, J_EN=0, CNT_W=4 sharing the same inputs; per-instruction state traces vs a sequence model.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_LW  = 7'b000_0011;
  localparam logic [6:0] OP_SW  = 7'b010_0011;
  localparam logic [6:0] OP_R   = 7'b011_0011;
  localparam logic [6:0] OP_I   = 7'b001_0011;
  localparam logic [6:0] OP_BEQ = 7'b110_0011;
  localparam logic [6:0] OP_JAL = 7'b110_1111;
  localparam logic [6:0] OP_LUI = 7'b011_0111;
  localparam logic [6:0] OP_BAD = 7'h7F;

  logic        CLK, RST, Zero, MemReady;
  logic [6:0]  OP;
  logic        PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, Illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOP;
  logic [2:0]  ImmSrc;
  logic [3:0]  State;
  logic [15:0] InstrCount;
  logic        bPCWrite, bAdrSrc, bIRWrite, bMemWrite, bRegWrite, bIllegal;
  logic [1:0]  bResultSrc, bALUSrcA, bALUSrcB, bALUOP;
  logic [2:0]  bImmSrc;
  logic [3:0]  bState;
  logic [3:0]  bInstrCount;

  int compared = 0;
  int mismatched = 0;

  int   expState[64];
  logic drvRdy[64];
  int   expLen;
  int   obsState[64];
  int   obsStateB[64];
  logic obsPCW[64], obsIRW[64], obsMW[64], obsRW[64];
  logic [1:0] obsRS[64], obsSrcA[64];
  logic [2:0] obsImm[64];
  int   obsCycles;

  multicycle_control_fsm dut (
    .CLK(CLK), .RST(RST), .OP(OP), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOP(ALUOP), .ImmSrc(ImmSrc), .Illegal(Illegal), .State(State), .InstrCount(InstrCount)
  );

  multicycle_control_fsm #(.MEM_WAIT_EN(1'b0), .J_EN(1'b0), .CNT_W(4)) dutB (
    .CLK(CLK), .RST(RST), .OP(OP), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(bPCWrite), .AdrSrc(bAdrSrc), .IRWrite(bIRWrite), .MemWrite(bMemWrite),
    .RegWrite(bRegWrite), .ResultSrc(bResultSrc), .ALUSrcA(bALUSrcA), .ALUSrcB(bALUSrcB),
    .ALUOP(bALUOP), .ImmSrc(bImmSrc), .Illegal(bIllegal), .State(bState), .InstrCount(bInstrCount)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic pushStep(input int st, input logic rdy);
    if (expLen < 64) begin
      expState[expLen] = st;
      drvRdy[expLen]   = rdy;
      expLen++;
    end
  endtask

  // Reference model: the state walk of one instruction, with each wait cycle as a repeated step.
  task automatic buildExpected(input logic [6:0] op, input int fw, input int mw);
    expLen = 0;
    repeat (fw) pushStep(0, 1'b0);
    pushStep(0, 1'b1);
    pushStep(1, 1'($urandom_range(0, 1)));
    case (op)
      OP_LW: begin
        pushStep(2, 1'($urandom_range(0, 1)));
        repeat (mw) pushStep(3, 1'b0);
        pushStep(3, 1'b1);
        pushStep(4, 1'($urandom_range(0, 1)));
      end
      OP_SW: begin
        pushStep(2, 1'($urandom_range(0, 1)));
        repeat (mw) pushStep(5, 1'b0);
        pushStep(5, 1'b1);
      end
      OP_R:   begin pushStep(6, 1'($urandom_range(0, 1)));  pushStep(8, 1'($urandom_range(0, 1))); end
      OP_I:   begin pushStep(7, 1'($urandom_range(0, 1)));  pushStep(8, 1'($urandom_range(0, 1))); end
      OP_BEQ: pushStep(9, 1'($urandom_range(0, 1)));
      OP_JAL: begin pushStep(10, 1'($urandom_range(0, 1))); pushStep(8, 1'($urandom_range(0, 1))); end
      OP_LUI: begin pushStep(11, 1'($urandom_range(0, 1))); pushStep(8, 1'($urandom_range(0, 1))); end
      default: repeat (40) pushStep(12, 1'($urandom_range(0, 1)));
    endcase
  endtask

  // Drives one instruction from FETCH and records what both instances did each cycle.
  task automatic runInstr(input logic [6:0] op, input logic zero, input int fw, input int mw);
    bit left;
    buildExpected(op, fw, mw);
    OP = op;
    Zero = zero;
    left = 0;
    obsCycles = 99;
    for (int k = 0; k < 48; k++) begin
      MemReady = (k < expLen) ? drvRdy[k] : 1'b1;
      #1;
      obsState[k]  = int'(State);
      obsStateB[k] = int'(bState);
      obsPCW[k] = PCWrite;  obsIRW[k] = IRWrite;
      obsMW[k]  = MemWrite; obsRW[k]  = RegWrite;
      obsRS[k]  = ResultSrc; obsSrcA[k] = ALUSrcA; obsImm[k] = ImmSrc;
      if (State != 4'd0) left = 1;
      @(posedge CLK);
      #1;
      if (left && State == 4'd0) begin
        obsCycles = k + 1;
        break;
      end
    end
  endtask

  task automatic doReset();
    RST = 1'b0;
    MemReady = 1'b1;
    OP = OP_R;
    Zero = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    runInstr(OP_R, 1'b0, 0, 0);
    compared++;
    if (InstrCount !== 16'd1) begin mismatched++; $display("[TB] FAIL reset_precount: got %0d want 1", InstrCount); end
    OP = OP_SW;
    MemReady = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    MemReady = 1'b0;
    #1;
    compared++;
    if (State !== 4'd5 || MemWrite !== 1'b1) begin
      mismatched++; $display("[TB] FAIL reset_inMemWrite: got state %0d mw %0b want 5 1", State, MemWrite);
    end
    RST = 1'b0;
    #1;
    compared++;
    if (State !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_state: got %0d want 0", State); end
    compared++;
    if (MemWrite !== 1'b0 || RegWrite !== 1'b0 || IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_enables: got mw%0b rw%0b ir%0b pc%0b want 0000", MemWrite, RegWrite, IRWrite, PCWrite);
    end
    compared++;
    if (InstrCount !== 16'd0 || Illegal !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_count: got cnt %0d ill %0b want 0 0", InstrCount, Illegal);
    end
    compared++;
    if ({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOP} !== {1'b0, 2'b00, 2'b10, 2'b10, 2'b00}) begin
      mismatched++; $display("[TB] FAIL reset_muxes: got %b want 000101000", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOP});
    end
    MemReady = 1'b1;
    #1;
    compared++;
    if (IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_readyForced: got ir%0b pc%0b want 0 0", IRWrite, PCWrite);
    end
    @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    compared++;
    if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
      mismatched++; $display("[TB] FAIL reset_firstFetch: got ir%0b pc%0b want 1 1", IRWrite, PCWrite);
    end
    @(posedge CLK);
    #1;
    compared++;
    if (State !== 4'd1) begin mismatched++; $display("[TB] FAIL reset_toDecode: got %0d want 1", State); end
  endtask

  task automatic test_mix();
    logic [6:0] ops[5] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ};
    int cyc[5] = '{5, 4, 4, 4, 3};
    doReset();
    for (int i = 0; i < 5; i++) begin
      runInstr(ops[i], 1'($urandom_range(0, 1)), 0, 0);
      compared++;
      if (obsCycles !== cyc[i]) begin
        mismatched++; $display("[TB] FAIL mix_cycles[%0d]: got %0d want %0d", i, obsCycles, cyc[i]);
      end
      if (i == 0) begin
        compared++;
        if (obsRW[4] !== 1'b1 || obsRS[4] !== 2'b01) begin
          mismatched++; $display("[TB] FAIL mix_lwWriteback: got rw%0b rs%0b want 1 01", obsRW[4], obsRS[4]);
        end
      end
    end
    compared++;
    if (InstrCount !== 16'd5) begin mismatched++; $display("[TB] FAIL mix_count: got %0d want 5", InstrCount); end
  endtask

  task automatic test_branch();
    doReset();
    runInstr(OP_BEQ, 1'b1, 0, 0);
    compared++;
    if (obsCycles !== 3 || obsState[2] !== 9 || obsPCW[2] !== 1'b1) begin
      mismatched++; $display("[TB] FAIL branch_taken: got cyc %0d st %0d pc %0b want 3 9 1", obsCycles, obsState[2], obsPCW[2]);
    end
    runInstr(OP_BEQ, 1'b0, 0, 0);
    compared++;
    if (obsCycles !== 3 || obsState[2] !== 9 || obsPCW[2] !== 1'b0) begin
      mismatched++; $display("[TB] FAIL branch_notTaken: got cyc %0d st %0d pc %0b want 3 9 0", obsCycles, obsState[2], obsPCW[2]);
    end
  endtask

  task automatic test_wait();
    int bCyc;
    doReset();
    runInstr(OP_LW, 1'b0, 3, 2);
    compared++;
    if (obsCycles !== 10) begin mismatched++; $display("[TB] FAIL wait_cycles: got %0d want 10", obsCycles); end
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (obsIRW[k] !== (k == 3)) begin
        mismatched++; $display("[TB] FAIL wait_irWrite[%0d]: got %0b want %0b", k, obsIRW[k], (k == 3));
      end
    end
    for (int k = 0; k < 10; k++) begin
      compared++;
      if (obsState[k] !== expState[k]) begin
        mismatched++; $display("[TB] FAIL wait_trace[%0d]: got %0d want %0d", k, obsState[k], expState[k]);
      end
    end
    bCyc = 99;
    for (int k = 1; k < 10; k++)
      if (bCyc == 99 && obsStateB[k] == 0 && obsStateB[k-1] != 0) bCyc = k;
    compared++;
    if (bCyc !== 5) begin mismatched++; $display("[TB] FAIL wait_noWaitCycles: got %0d want 5", bCyc); end
  endtask

  task automatic test_jal_lui();
    doReset();
    runInstr(OP_JAL, 1'b0, 0, 0);
    compared++;
    if (obsCycles !== 4 || obsState[2] !== 10 || obsPCW[2] !== 1'b1) begin
      mismatched++; $display("[TB] FAIL jal_exec: got cyc %0d st %0d pc %0b want 4 10 1", obsCycles, obsState[2], obsPCW[2]);
    end
    compared++;
    if (obsImm[1] !== 3'b011) begin mismatched++; $display("[TB] FAIL jal_imm: got %b want 011", obsImm[1]); end
    compared++;
    if (obsStateB[2] !== 12) begin mismatched++; $display("[TB] FAIL jal_disabled: got %0d want 12", obsStateB[2]); end
    runInstr(OP_LUI, 1'b0, 0, 0);
    compared++;
    if (obsCycles !== 4 || obsState[2] !== 11 || obsSrcA[2] !== 2'b11 || obsImm[2] !== 3'b100) begin
      mismatched++; $display("[TB] FAIL lui_exec: got cyc %0d st %0d a %b imm %b want 4 11 11 100", obsCycles, obsState[2], obsSrcA[2], obsImm[2]);
    end
    compared++;
    if (bIllegal !== 1'b1) begin mismatched++; $display("[TB] FAIL jal_disabledIllegal: got %0b want 1", bIllegal); end
  endtask

  task automatic test_illegal();
    int writes;
    doReset();
    runInstr(OP_BAD, 1'b1, 0, 0);
    compared++;
    if (obsCycles !== 99 || State !== 4'd12 || Illegal !== 1'b1) begin
      mismatched++; $display("[TB] FAIL illegal_trap: got cyc %0d st %0d ill %0b want 99 12 1", obsCycles, State, Illegal);
    end
    writes = 0;
    for (int k = 2; k < 48; k++) begin
      if (obsPCW[k] || obsIRW[k] || obsMW[k] || obsRW[k]) writes++;
      if (obsState[k] != 12) writes++;
    end
    compared++;
    if (writes !== 0) begin mismatched++; $display("[TB] FAIL illegal_hold: got %0d bad cycles want 0", writes); end
    RST = 1'b0;
    #1;
    compared++;
    if (Illegal !== 1'b0 || State !== 4'd0) begin
      mismatched++; $display("[TB] FAIL illegal_clear: got ill %0b st %0d want 0 0", Illegal, State);
    end
    RST = 1'b1;
  endtask

  task automatic test_wrap();
    logic [6:0] ops[5] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ};
    doReset();
    for (int i = 0; i < 17; i++)
      runInstr(ops[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), 0, 0);
    compared++;
    if (InstrCount !== 16'd17) begin mismatched++; $display("[TB] FAIL wrap_count16: got %0d want 17", InstrCount); end
    compared++;
    if (bInstrCount !== 4'd1) begin mismatched++; $display("[TB] FAIL wrap_count4: got %0d want 1", bInstrCount); end
  endtask

  task automatic test_random();
    logic [6:0] ops[7] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_LUI};
    logic zero;
    int st, cnt;
    logic rdy, eIRW, ePCW, eMW, eRW;
    doReset();
    cnt = 0;
    for (int n = 0; n < 30; n++) begin
      zero = 1'($urandom_range(0, 1));
      runInstr(ops[$urandom_range(0, 6)], zero, $urandom_range(0, 2), $urandom_range(0, 2));
      cnt++;
      compared++;
      if (obsCycles !== expLen) begin
        mismatched++; $display("[TB] FAIL rand_cycles[%0d]: got %0d want %0d", n, obsCycles, expLen);
      end else begin
        for (int k = 0; k < expLen; k++) begin
          st = expState[k];
          rdy = drvRdy[k];
          eIRW = (st == 0) && rdy;
          ePCW = ((st == 0) && rdy) || (st == 10) || ((st == 9) && zero);
          eMW = (st == 5);
          eRW = (st == 4) || (st == 8);
          compared++;
          if (obsState[k] !== st || obsIRW[k] !== eIRW || obsPCW[k] !== ePCW || obsMW[k] !== eMW || obsRW[k] !== eRW) begin
            mismatched++;
            $display("[TB] FAIL rand_step[%0d.%0d]: got st %0d ir%0b pc%0b mw%0b rw%0b want st %0d ir%0b pc%0b mw%0b rw%0b",
                     n, k, obsState[k], obsIRW[k], obsPCW[k], obsMW[k], obsRW[k], st, eIRW, ePCW, eMW, eRW);
          end
        end
      end
      compared++;
      if (InstrCount !== 16'(cnt)) begin
        mismatched++; $display("[TB] FAIL rand_count[%0d]: got %0d want %0d", n, InstrCount, cnt);
      end
    end
  endtask

  initial begin
    RST = 1'b0;
    OP = OP_R;
    Zero = 1'b0;
    MemReady = 1'b1;
    test_reset();
    test_mix();
    test_branch();
    test_wait();
    test_jal_lui();
    test_illegal();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multicycle successor to the single-cycle main decoder: a Moore control state machine that sequences each RISC-V instruction over 3–5 cycles on a shared instruction/data memory. It sits between the instruction register (which supplies `OP`) and the datapath muxes, register file, PC and memory. Extensions beyond the single-cycle decoder:
- memory wait-state handshake;
- optional jal/lui support;
- sticky illegal-opcode trap;
- retired-instruction counter.

## Interface
- `MEM_WAIT_EN`, default 1: 1 = honour `MemReady`; 0 = treat `MemReady` as always 1.
- `J_EN`, default 1: 1 = decode jal (110_1111) and lui (011_0111); 0 = both are illegal.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, asynchronous, active-low.
- `OP` in 7: opcode from the instruction register.
- `Zero` in 1: ALU zero flag.
- `MemReady` in 1: memory access completes this cycle.
- `PCWrite` out 1: PC load enable.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: instruction and OldPC register load.
- `MemWrite` out 1: memory write strobe.
- `RegWrite` out 1: register file write.
- `ResultSrc` out 2: result mux; 00 ALUOut, 01 Data, 10 ALUResult.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 RD1, 11 zero.
- `ALUSrcB` out 2: 00 RD2, 01 Imm, 10 constant 4.
- `ALUOP` out 2: 00 add, 01 sub/branch, 10 funct-decoded.
- `ImmSrc` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `Illegal` out 1: sticky trap flag.
- `State` out 4: current state, for debug.
- `InstrCount` out CNT_W: retired instructions.

## Operation
State encoding:
- 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE
- 6 EXECR, 7 EXECI, 8 ALUWB, 9 BEQ, 10 JAL, 11 LUI, 12 TRAP

Per-state outputs and transitions. Unlisted outputs are 0 / 00. `PCWrite = PCUpdate | (branch & Zero)`.
- **FETCH:** `AdrSrc=0`, `ALUSrcA=00`, `ALUSrcB=10`, `ResultSrc=10`. `IRWrite` and `PCUpdate` asserted only when `MemReady`. Stays in FETCH while `!MemReady`, else goes to DECODE.
- **DECODE:** `ALUSrcA=01`, `ALUSrcB=01` (branch target into ALUOut). Next state by `OP`:
  - 000_0011 or 010_0011 → MEMADR
  - 011_0011 → EXECR
  - 001_0011 → EXECI
  - 110_0011 → BEQ
  - 110_1111 → JAL (if `J_EN`)
  - 011_0111 → LUI (if `J_EN`)
  - anything else → TRAP
- **MEMADR:** `ALUSrcA=10`, `ALUSrcB=01`. Goes to MEMREAD for 000_0011, MEMWRITE for 010_0011.
- **MEMREAD:** `AdrSrc=1`, `ResultSrc=00`. Waits for `MemReady`, then goes to MEMWB.
- **MEMWB:** `ResultSrc=01`, `RegWrite=1`. Goes to FETCH.
- **MEMWRITE:** `AdrSrc=1`, `MemWrite=1`, held every cycle until `MemReady`. Then goes to FETCH.
- **EXECR:** `ALUSrcA=10`, `ALUSrcB=00`, `ALUOP=10`. Goes to ALUWB.
- **EXECI:** `ALUSrcA=10`, `ALUSrcB=01`, `ALUOP=10`. Goes to ALUWB.
- **ALUWB:** `ResultSrc=00`, `RegWrite=1`. Goes to FETCH.
- **BEQ:** `ALUSrcA=10`, `ALUSrcB=00`, `ALUOP=01`, `ResultSrc=00`, `branch=1`. Goes to FETCH.
- **JAL:** `ALUSrcA=01`, `ALUSrcB=10`, `ResultSrc=00`, `PCUpdate=1`. Goes to ALUWB.
- **LUI:** `ALUSrcA=11`, `ALUSrcB=01`. Goes to ALUWB.
- **TRAP:** all enables 0, `Illegal=1`. Stays in TRAP until reset.

ImmSrc, a combinational function of `OP` in every state:
- 010_0011 → 001
- 110_0011 → 010
- 110_1111 → 011
- 011_0111 → 100
- otherwise → 000

InstrCount:
- Increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
- Wraps modulo 2^CNT_W; no saturation.

## Timing
- **Reset:**
  - While `RST=0`: state = FETCH, `InstrCount=0`, `Illegal=0`.
  - `PCWrite`, `IRWrite`, `MemWrite`, `RegWrite` are forced to 0.
  - Mux selects show FETCH values: `AdrSrc=0`, `ALUSrcA=00`, `ALUSrcB=10`, `ResultSrc=10`, `ALUOP=00`.
  - Reset asserted mid-instruction aborts it immediately; no partial write is issued after the `RST` edge.
- **Outputs:** decoded from the state register (Moore), except:
  - `ImmSrc` follows `OP` combinationally;
  - `PCWrite` in BEQ depends combinationally on `Zero`;
  - FETCH enables depend combinationally on `MemReady`.
- **Cycle counts with zero wait states:**
  - lw: 5
  - sw: 4
  - R-type and I-type ALU: 4
  - beq: 3
  - jal: 4
  - lui: 4
- **Wait states:** each cycle of `MemReady=0` in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- **MEM_WAIT_EN=0:** `MemReady` is ignored, and the counts above are exact.

## Test plan
- **Reset and first fetch.** Hold `RST=0` mid-MEMWRITE, then release with `MemReady=1`.
  - During reset: `State=0`, `MemWrite=0`, `InstrCount=0`.
  - First cycle after release: `IRWrite=1`, `PCWrite=1`.
- **Zero-wait instruction mix.** Run lw, sw, add, addi, beq with `MemReady=1`.
  - Cycles per instruction: 5/4/4/4/3.
  - `InstrCount` reaches 5.
  - lw `RegWrite` occurs with `ResultSrc=01`.
- **Branch resolution.** beq with `Zero=1` asserts `PCWrite=1` in BEQ. With `Zero=0`, `PCWrite=0`. Both return to FETCH.
- **Wait states.** lw with `MemReady` low for 3 cycles in FETCH and 2 in MEMREAD.
  - Instruction takes 10 cycles.
  - `IRWrite` is high only in the ready cycle.
  - Repeated with `MEM_WAIT_EN=0`: 5 cycles.
- **jal/lui and J_EN.**
  - With `J_EN=1`, jal takes 4 cycles with `PCWrite=1` in JAL and `ImmSrc=011`; lui uses `ALUSrcA=11` and `ImmSrc=100`.
  - With `J_EN=0`, jal goes to TRAP.
- **Illegal opcode and counter wrap.**
  - `OP=7'h7F` → `Illegal=1` and `State=12`, held with no writes until `RST`.
  - With `CNT_W=4`, 17 retired instructions → `InstrCount=1`.
